// File: rtl/alu_issuer.sv
// alu_issuer: issues one 4-bit add/sub command at a time to an external ALU and queues the 5-bit results.
// Latency: command accepted at edge N, result captured at edge N+1, response visible right after N+1.
// Backpressure: cmd_ready drops while executing or when the RSP_DEPTH-entry response FIFO is full.
// Optional result checker enabled by macro ALU_ISSUER_CHECK_EN (err tied low when undefined).
module alu_issuer #(
  parameter int RSP_DEPTH = 2  // 2, 4 or 8 entries
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic       cmd_mode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_mode,
  input  logic [4:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [4:0] rsp_result,
  output logic       rsp_mode,
  output logic       busy,
  output logic       err
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t             state_q;
  logic [3:0]         alu_a_q;
  logic [3:0]         alu_b_q;
  logic               alu_mode_q;
  logic               busy_q;

  // Each entry is {result[4:0], mode}
  logic [5:0]         mem_q [RSP_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               accept;
  logic               push;
  logic               pop;
  logic [5:0]         head;

  // Handshake decode; only one command is ever in flight, so gating on count alone prevents overflow
  always_comb begin
    cmd_ready = (state_q == IDLE) && !rst && (count_q < CNT_W'(RSP_DEPTH));
    accept    = cmd_valid && cmd_ready;
    push      = (state_q == EXEC);
    rsp_valid = (count_q != '0);
    pop       = rsp_valid && rsp_ready;
    head      = mem_q[rd_ptr_q];
    // Gate the head with valid so stale storage never leaks onto the outputs
    rsp_result = rsp_valid ? head[5:1] : 5'd0;
    rsp_mode   = rsp_valid ? head[0]   : 1'b0;
  end

  // Two-state issue FSM with registered ALU operands and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_a_q    <= 4'd0;
      alu_b_q    <= 4'd0;
      alu_mode_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_a_q    <= cmd_a;
            alu_b_q    <= cmd_b;
            alu_mode_q <= cmd_mode;
            busy_q     <= 1'b1;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          // Operands are deliberately held after completion
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_mode = alu_mode_q;
  assign busy     = busy_q;

  // FIFO next-state; power-of-two depth lets the pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers; reset discards every queued entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; no reset needed because reads are masked while empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {alu_result, alu_mode_q};
  end

`ifdef ALU_ISSUER_CHECK_EN
  logic [4:0] exp_result;
  logic       err_q;

  // Reference add/sub, 5-bit wrap, compared against the ALU at the capture edge
  always_comb begin
    exp_result = alu_mode_q ? ({1'b0, alu_a_q} - {1'b0, alu_b_q})
                            : ({1'b0, alu_a_q} + {1'b0, alu_b_q});
  end

  // Sticky mismatch flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         err_q <= 1'b0;
    else if ((state_q == EXEC) && (alu_result != exp_result)) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
- REQ-001 SHALL have parameter RSP_DEPTH, default 2: number of response buffer entries; legal values are 2, 4 and 8.
- REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
- REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-004 SHALL have port cmd_valid, input, 1 bit: a command is offered.
- REQ-005 SHALL have port cmd_ready, output, 1 bit: the issuer accepts the command.
- REQ-006 SHALL have port cmd_a, input, 4 bits: operand A.
- REQ-007 SHALL have port cmd_b, input, 4 bits: operand B.
- REQ-008 SHALL have port cmd_mode, input, 1 bit: 0 = add, 1 = subtract.
- REQ-009 SHALL have port alu_a, output, 4 bits: operand A driven to the ALU.
- REQ-010 SHALL have port alu_b, output, 4 bits: operand B driven to the ALU.
- REQ-011 SHALL have port alu_mode, output, 1 bit: mode driven to the ALU.
- REQ-012 SHALL have port alu_result, input, 5 bits: combinational result returned by the ALU.
- REQ-013 SHALL have port rsp_valid, output, 1 bit: the response buffer head is valid.
- REQ-014 SHALL have port rsp_ready, input, 1 bit: the consumer takes the head entry.
- REQ-015 SHALL have port rsp_result, output, 5 bits: the head entry's result.
- REQ-016 SHALL have port rsp_mode, output, 1 bit: the head entry's mode.
- REQ-017 SHALL have port busy, output, 1 bit: high while in EXEC.
- REQ-018 SHALL have port err, output, 1 bit: sticky result-check error (see Configuration).

Function
- REQ-019 SHALL implement FSM states IDLE and EXEC.
- REQ-020 SHALL drive cmd_ready = 1 only in IDLE, with rst low and buffer count < RSP_DEPTH.
- REQ-021 SHALL treat a command as accepted at a rising edge where cmd_valid && cmd_ready.
- REQ-022 SHALL, on acceptance, register cmd_a/cmd_b/cmd_mode into alu_a/alu_b/alu_mode and move IDLE->EXEC.
- REQ-023 SHALL, at the next edge in EXEC, push {alu_result, alu_mode} into the buffer and move EXEC->IDLE.
- REQ-024 SHALL therefore have 2-edge latency: accepted at edge N, result sampled at edge N+1, rsp_valid high from just after edge N+1.
- REQ-025 SHALL have throughput of at most one command per 2 cycles.
- REQ-026 SHALL hold alu_a/alu_b/alu_mode at the last issued values after completion; they are not cleared.
- REQ-027 SHALL pass alu_result through unmodified: no sign extension, no saturation.
- REQ-028 SHALL operate the buffer as a FIFO, oldest first.
- REQ-029 SHALL assert rsp_valid whenever count > 0; rsp_result/rsp_mode show the head entry.
- REQ-030 SHALL pop the head at an edge where rsp_valid && rsp_ready.
- REQ-031 SHALL leave count unchanged on a simultaneous push and pop at the same edge.
- REQ-032 SHALL never overflow: acceptance is gated by REQ-020 and only one command is ever in flight.
- REQ-033 SHALL ignore rsp_ready while empty, with no count underflow.
- REQ-034 SHALL wrap buffer pointers modulo RSP_DEPTH.
- REQ-035 SHALL ignore cmd_* inputs while cmd_ready = 0.

Reset
- REQ-036 SHALL, while rst is high, asynchronously force: state = IDLE, buffer empty, pointers = 0, rsp_valid = 0, rsp_result = 0, rsp_mode = 0, alu_a = 0, alu_b = 0, alu_mode = 0, busy = 0, err = 0, cmd_ready = 0.
- REQ-037 SHALL discard any in-flight EXEC operation and all buffered entries on reset mid-operation; no response is produced for them.
- REQ-038 SHALL allow cmd_ready = 1 in the first cycle after rst deasserts.

Configuration
- REQ-039 SHALL compile a result checker when macro ALU_ISSUER_CHECK_EN is defined.
- REQ-040 SHALL, with the macro defined, compute expected = ({1'b0,alu_a} + {1'b0,alu_b}) mod 32 for mode 0, or ({1'b0,alu_a} - {1'b0,alu_b}) mod 32 for mode 1.
- REQ-041 SHALL, with the macro defined, compare expected to alu_result at the EXEC sampling edge and set err = 1 on mismatch; err stays set until reset.
- REQ-042 SHALL, without the macro, tie err to 0 and instantiate no checker logic; all other behaviour is identical.

Verification
- REQ-043 Bench SHALL cover: rst pulse mid-run -> all outputs 0 during reset; cmd_ready = 1 in the first cycle after release.
- REQ-044 Bench SHALL cover: a = 9, b = 8, mode = 0, rsp_ready = 1 -> rsp_result = 17, rsp_mode = 0, rsp_valid after edge N+1, one cycle wide.
- REQ-045 Bench SHALL cover: a = 3, b = 5, mode = 1 -> rsp_result = 5'b11110 (30).
- REQ-046 Bench SHALL cover: RSP_DEPTH = 2, rsp_ready = 0, three back-to-back commands (1+1, 2+2, 3+3) -> two accepted, then cmd_ready = 0; one pop -> third accepted; responses come out 2, 4, 6 in order.
- REQ-047 Bench SHALL cover: rst asserted while busy = 1 -> no response ever appears for that command.
- REQ-048 Bench SHALL cover: with ALU_ISSUER_CHECK_EN, alu_result forced to 0 for a = 1, b = 1, mode = 0 -> err = 1 and stays 1 until rst; without the macro -> err = 0.
